// File: rtl/inst_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | inst_loader_pkg : shared widths, loader state encoding and address helper   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef ADDR_LEN
`define ADDR_LEN 64
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

package inst_loader_pkg;

   localparam int LEN_FIELD_W = 32;

   typedef enum logic [2:0] {
      ST_LEN  = 3'd0,
      ST_DATA = 3'd1,
      ST_CSUM = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } ld_state_e;

   // Byte address of word idx; wraps modulo 2^ADDR_LEN by construction.
   function automatic logic [`ADDR_LEN-1:0] word_addr(input logic [`ADDR_LEN-1:0] base,
                                                      input logic [LEN_FIELD_W-1:0] idx);
      return base + `ADDR_LEN'({idx, 2'b00});
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
// +----------------------------------------------------------------------------+
// | byte_packer : 4-byte little-endian word assembler with 1-cycle word strobe |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module byte_packer (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 byte_en_i,
   input  logic [7:0]           byte_i,
   output logic                 last_lane_o,
   output logic                 word_valid_o,
   output logic [`INST_LEN-1:0] word_o
);

   logic [1:0]           lane_q, lane_d;
   logic [23:0]          asm_q, asm_d;
   logic                 wv_q, wv_d;
   logic [`INST_LEN-1:0] word_q, word_d;

   assign last_lane_o  = (lane_q == 2'd3);
   assign word_valid_o = wv_q;
   assign word_o       = word_q;

   always_comb begin
      lane_d = lane_q;
      asm_d  = asm_q;
      wv_d   = 1'b0;
      word_d = '0;
      if (byte_en_i) begin
         if (lane_q == 2'd3) begin
            wv_d   = 1'b1;
            word_d = {byte_i, asm_q};
            lane_d = 2'd0;
            asm_d  = '0;
         end else begin
            // Shift right so earlier bytes settle into the low lanes.
            lane_d = lane_q + 2'd1;
            asm_d  = {byte_i, asm_q[23:8]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lane_q <= 2'd0;
         asm_q  <= '0;
         wv_q   <= 1'b0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         asm_q  <= asm_d;
         wv_q   <= wv_d;
         word_q <= word_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// +----------------------------------------------------------------------------+
// | inst_loader : byte-stream program loader into instruction memory           |
// | Optional trailing XOR checksum byte enabled by macro LOADER_CHECKSUM_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_loader
   import inst_loader_pkg::*;
#(
   parameter logic [`ADDR_LEN-1:0] BASE_ADDR = 64'h0,
   parameter int                   MAX_WORDS = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_i,
   output logic                 byte_ready_o,
   output logic                 mem_wen_o,
   output logic [`ADDR_LEN-1:0] mem_waddr_o,
   output logic [`INST_LEN-1:0] mem_wdata_o,
   output logic                 hold_o,
   output logic                 done_o,
   output logic                 err_o
);

   ld_state_e                state_q, state_d;
   logic [1:0]               len_cnt_q, len_cnt_d;
   logic [23:0]              len_lo_q, len_lo_d;
   logic [LEN_FIELD_W-1:0]   n_q, n_d;
   logic [LEN_FIELD_W-1:0]   word_cnt_q, word_cnt_d;
   logic [`ADDR_LEN-1:0]     waddr_q, waddr_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]               csum_q, csum_d;
`endif

   logic                     accept;
   logic                     data_en;
   logic                     last_lane;
   logic                     word_valid;
   logic [`INST_LEN-1:0]     word;
   logic [LEN_FIELD_W-1:0]   len_full;

   assign byte_ready_o = rst && ((state_q == ST_LEN) || (state_q == ST_DATA) ||
                                 (state_q == ST_CSUM));
   assign accept       = byte_valid_i && byte_ready_o;
   assign data_en      = accept && (state_q == ST_DATA);
   assign len_full     = {byte_i, len_lo_q};

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .byte_en_i    (data_en),
      .byte_i       (byte_i),
      .last_lane_o  (last_lane),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   // Address is registered alongside the packer's word so both land in the same cycle.
   assign mem_wen_o   = word_valid;
   assign mem_wdata_o = word;
   assign mem_waddr_o = waddr_q;
   assign hold_o      = (state_q != ST_DONE) || word_valid;
   assign done_o      = (state_q == ST_DONE);
   assign err_o       = (state_q == ST_ERR);

   always_comb begin
      state_d    = state_q;
      len_cnt_d  = len_cnt_q;
      len_lo_d   = len_lo_q;
      n_d        = n_q;
      word_cnt_d = word_cnt_q;
      waddr_d    = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         ST_LEN: begin
            if (accept) begin
               if (len_cnt_q == 2'd3) begin
                  n_d       = len_full;
                  len_cnt_d = 2'd0;
                  if (len_full > LEN_FIELD_W'(MAX_WORDS)) begin
                     state_d = ST_ERR;
                  end else if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     state_d = ST_CSUM;
`else
                     state_d = ST_DONE;
`endif
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  len_cnt_d = len_cnt_q + 2'd1;
                  len_lo_d  = {byte_i, len_lo_q[23:8]};
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_i;
`endif
               if (last_lane) begin
                  waddr_d    = word_addr(BASE_ADDR, word_cnt_q);
                  word_cnt_d = word_cnt_q + LEN_FIELD_W'(1);
                  if ((word_cnt_q + LEN_FIELD_W'(1)) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                     state_d = ST_CSUM;
`else
                     state_d = ST_DONE;
`endif
                  end
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (accept) begin
               state_d = (byte_i == csum_q) ? ST_DONE : ST_ERR;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_LEN;
         len_cnt_q  <= 2'd0;
         len_lo_q   <= '0;
         n_q        <= '0;
         word_cnt_q <= '0;
         waddr_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_cnt_q  <= len_cnt_d;
         len_lo_q   <= len_lo_d;
         n_q        <= n_d;
         word_cnt_q <= word_cnt_d;
         waddr_q    <= waddr_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// +----------------------------------------------------------------------------+
// | tb_inst_loader : scoreboard bench, two loaders (base 0 and base 0x1000)    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_inst_loader;

   localparam int          MAXW   = 1024;
   localparam logic [63:0] BASE_A = 64'h0;
   localparam logic [63:0] BASE_B = 64'h1000;

   typedef struct packed {
      logic [63:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        byte_valid_i;
   logic [7:0]  byte_i;

   logic        a_ready, a_wen, a_hold, a_done, a_err;
   logic [63:0] a_addr;
   logic [31:0] a_data;
   logic        b_ready, b_wen, b_hold, b_done, b_err;
   logic [63:0] b_addr;
   logic [31:0] b_data;

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   wr_t         exp_a[$];
   wr_t         exp_b[$];
   logic [31:0] prog[$];

   always #5 clk = ~clk;

   inst_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAXW)) dut_a (
      .clk(clk), .rst(rst), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
      .byte_ready_o(a_ready), .mem_wen_o(a_wen), .mem_waddr_o(a_addr),
      .mem_wdata_o(a_data), .hold_o(a_hold), .done_o(a_done), .err_o(a_err)
   );

   inst_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAXW)) dut_b (
      .clk(clk), .rst(rst), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
      .byte_ready_o(b_ready), .mem_wen_o(b_wen), .mem_waddr_o(b_addr),
      .mem_wdata_o(b_data), .hold_o(b_hold), .done_o(b_done), .err_o(b_err)
   );

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic mon(input int id, input logic wen, input logic [63:0] ad,
                      input logic [31:0] dt, input logic hold);
      wr_t e;
      int  sz;
      if (wen === 1'b1) begin
         sz = (id == 0) ? exp_a.size() : exp_b.size();
         checks++;
         if (sz == 0) begin
            errors++;
            $display("FAIL unexpected_write dut%0d actual addr=%0h data=%0h required no write",
                     id, ad, dt);
         end else begin
            if (id == 0) e = exp_a.pop_front();
            else         e = exp_b.pop_front();
            chk($sformatf("write dut%0d", id), {ad, dt}, {e.a, e.d});
         end
         chk($sformatf("hold_in_write dut%0d", id), 96'(hold), 96'd1);
      end else begin
         chk($sformatf("idle_bus dut%0d", id), {ad, dt}, 96'd0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, a_wen, a_addr, a_data, a_hold);
         mon(1, b_wen, b_addr, b_data, b_hold);
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      bit acc = 1'b0;
      int cyc = 0;
      while (!acc) begin
         @(negedge clk);
         byte_valid_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         byte_i       = byte_valid_i ? b : 8'($urandom);
         #1;
         if (byte_valid_i && a_ready) acc = 1'b1;
         cyc++;
         if (!acc && cyc > 50) begin
            chk("byte_accept_timeout", 96'(a_ready), 96'd1);
            acc = 1'b1;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst          = 1'b0;
      byte_valid_i = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b1;
   endtask

   // Reference: stream = LEN(4B LE) + words LE + [xor of data bytes]; one write per whole word.
   task automatic run_load(input logic [31:0] n, input bit bad_csum, input bit rnd,
                           input int cut);
      logic [7:0]  s[$];
      logic [7:0]  cs;
      logic [7:0]  bv;
      logic [31:0] w;
      int          nwr;
      bit          exp_done;
      s  = {};
      cs = 8'h00;
      for (int i = 0; i < 4; i++) s.push_back(n[8*i +: 8]);
      if (n <= 32'(MAXW)) begin
         for (int k = 0; k < int'(n); k++) begin
            w = prog[k];
            for (int b = 0; b < 4; b++) begin
               bv = w[8*b +: 8];
               s.push_back(bv);
               cs = cs ^ bv;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         s.push_back(bad_csum ? (cs ^ 8'h01) : cs);
`endif
      end
      if (cut >= 0) while (s.size() > 4 + cut) void'(s.pop_back());
      nwr = (n > 32'(MAXW)) ? 0 : int'(n);
      if (cut >= 0 && cut / 4 < nwr) nwr = cut / 4;
      for (int k = 0; k < nwr; k++) begin
         exp_a.push_back('{a: BASE_A + 64'(4 * k), d: prog[k]});
         exp_b.push_back('{a: BASE_B + 64'(4 * k), d: prog[k]});
      end
      exp_done = (n <= 32'(MAXW));
`ifdef LOADER_CHECKSUM_EN
      if (bad_csum) exp_done = 1'b0;
`endif
      foreach (s[i]) send_byte(s[i], rnd);
      @(negedge clk);
      byte_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("pending_writes a", 96'(exp_a.size()), 96'd0);
      chk("pending_writes b", 96'(exp_b.size()), 96'd0);
      if (cut < 0) begin
         chk("end_state a", {a_done, a_err, a_hold, a_ready},
             {92'd0, exp_done, !exp_done, !exp_done, 1'b0});
         chk("end_state b", {b_done, b_err, b_hold, b_ready},
             {92'd0, exp_done, !exp_done, !exp_done, 1'b0});
         repeat (3) begin
            @(negedge clk);
            byte_valid_i = 1'b1;
            byte_i       = 8'($urandom);
            #1;
            chk("terminal_ready", 96'({a_ready, b_ready}), 96'd0);
         end
         @(negedge clk);
         byte_valid_i = 1'b0;
         repeat (2) @(negedge clk);
         chk("terminal_hold a", 96'(a_hold), 96'(!exp_done));
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst          = 1'b0;
      byte_valid_i = 1'b0;
      byte_i       = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_outputs a", {a_ready, a_wen, a_addr, a_data[27:0], a_hold, a_done, a_err},
          {1'b0, 1'b0, 64'd0, 28'd0, 1'b1, 1'b0, 1'b0});
      chk("reset_outputs b", {b_ready, b_wen, b_addr, b_data[27:0], b_hold, b_done, b_err},
          {1'b0, 1'b0, 64'd0, 28'd0, 1'b1, 1'b0, 1'b0});
      chk("reset_data", {a_data, b_data}, 96'd0);
      mon_en = 1'b1;
      rst    = 1'b1;
      #1;
      chk("ready_after_reset", 96'({a_ready, b_ready}), 96'd3);

      prog = {32'h00000013, 32'h00100093};
      run_load(32'd2, 1'b0, 1'b0, -1);

      do_reset(2);
      prog = {};
      run_load(32'd1025, 1'b0, 1'b0, -1);

      do_reset(2);
      prog = {32'h00000013, 32'h00100093};
      run_load(32'd2, 1'b0, 1'b1, -1);

      do_reset(2);
      run_load(32'd2, 1'b0, 1'b0, 6);
      do_reset(2);
      prog = {32'h00000013};
      run_load(32'd1, 1'b0, 1'b0, -1);

      do_reset(2);
      prog = {};
      run_load(32'd0, 1'b0, 1'b0, -1);

`ifdef LOADER_CHECKSUM_EN
      do_reset(2);
      prog = {32'h00000013};
      run_load(32'd1, 1'b0, 1'b0, -1);
      do_reset(2);
      run_load(32'd1, 1'b1, 1'b0, -1);
`endif

      for (int t = 0; t < 6; t++) begin
         do_reset(1 + (t % 2));
         n    = $urandom_range(1, 5);
         prog = {};
         for (int k = 0; k < n; k++) prog.push_back($urandom);
         run_load(32'(n), 1'($urandom_range(0, 1)), 1'b1, -1);
      end

      do_reset(2);
      prog = {};
      for (int k = 0; k < MAXW; k++) prog.push_back($urandom);
      run_load(32'(MAXW), 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
